// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline buffer bus: decode-side inputs and execute-side outputs.
// master drives the decode side and observes; slave is the buffer itself.
interface id_ex_pipe_reg_if #(
   parameter int DATA_W = 32,
   parameter int PC_W   = 8,
   parameter int REG_W  = 5,
   parameter int M_W    = 4,
   parameter int WB_W   = 2,
   parameter int CNT_W  = 16
);
   logic              stall_IN;
   logic              flush_IN;
   logic              valid_IN;
   logic [PC_W-1:0]   nextInst_IN;
   logic [DATA_W-1:0] regData1_IN;
   logic [DATA_W-1:0] regData2_IN;
   logic [DATA_W-1:0] imm_IN;
   logic [DATA_W-1:0] jump_IN;
   logic [REG_W-1:0]  rs_IN;
   logic [REG_W-1:0]  rt_IN;
   logic [REG_W-1:0]  rd_IN;
   logic [M_W-1:0]    M_IN;
   logic [WB_W-1:0]   WB_IN;
   logic [3:0]        EX_IN;

   logic              hazard_OUT;
   logic              valid_OUT;
   logic              RegDst;
   logic              ALUSrc;
   logic [1:0]        ALUOp;
   logic [M_W-1:0]    M_OUT;
   logic [WB_W-1:0]   WB_OUT;
   logic [PC_W-1:0]   nextInst_OUT;
   logic [DATA_W-1:0] regData1_OUT;
   logic [DATA_W-1:0] regData2_OUT;
   logic [DATA_W-1:0] imm_OUT;
   logic [DATA_W-1:0] jump_OUT;
   logic [REG_W-1:0]  rs_OUT;
   logic [REG_W-1:0]  rt_OUT;
   logic [REG_W-1:0]  rd_OUT;
   logic [CNT_W-1:0]  bubble_cnt;

   modport master (
      output stall_IN, flush_IN, valid_IN, nextInst_IN,
      output regData1_IN, regData2_IN, imm_IN, jump_IN,
      output rs_IN, rt_IN, rd_IN, M_IN, WB_IN, EX_IN,
      input  hazard_OUT, valid_OUT, RegDst, ALUSrc, ALUOp,
      input  M_OUT, WB_OUT, nextInst_OUT, regData1_OUT,
      input  regData2_OUT, imm_OUT, jump_OUT,
      input  rs_OUT, rt_OUT, rd_OUT, bubble_cnt
   );

   modport slave (
      input  stall_IN, flush_IN, valid_IN, nextInst_IN,
      input  regData1_IN, regData2_IN, imm_IN, jump_IN,
      input  rs_IN, rt_IN, rd_IN, M_IN, WB_IN, EX_IN,
      output hazard_OUT, valid_OUT, RegDst, ALUSrc, ALUOp,
      output M_OUT, WB_OUT, nextInst_OUT, regData1_OUT,
      output regData2_OUT, imm_OUT, jump_OUT,
      output rs_OUT, rt_OUT, rd_OUT, bubble_cnt
   );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline buffer with stall, flush, valid bit, load-use hazard
// detection, bubble insertion and a saturating bubble counter.
// Ports: clk_BF, rst_BF (async active-high), bus (slave side of the bus).
module id_ex_pipe_reg #(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 8,
   parameter int REG_W       = 5,
   parameter int M_W         = 4,
   parameter int WB_W        = 2,
   parameter int MEMREAD_BIT = 1,
   parameter int CNT_W       = 16
) (
   input  logic           clk_BF,
   input  logic           rst_BF,
   id_ex_pipe_reg_if.slave bus
);
   logic              valid_q, valid_d;
   logic              reg_dst_q, reg_dst_d;
   logic              alu_src_q, alu_src_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic [M_W-1:0]    m_q, m_d;
   logic [WB_W-1:0]   wb_q, wb_d;
   logic [PC_W-1:0]   next_inst_q, next_inst_d;
   logic [DATA_W-1:0] rd1_q, rd1_d;
   logic [DATA_W-1:0] rd2_q, rd2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] jump_q, jump_d;
   logic [REG_W-1:0]  rs_q, rs_d;
   logic [REG_W-1:0]  rt_q, rt_d;
   logic [REG_W-1:0]  rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              hazard;
   logic [CNT_W-1:0]  cnt_inc;

   // Load in stage whose target is read by the incoming instruction.
   always_comb begin
      hazard = valid_q & m_q[MEMREAD_BIT] & bus.valid_IN
             & (rt_q != '0)
             & ((rt_q == bus.rs_IN) | (rt_q == bus.rt_IN));
   end

   always_comb begin
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

      valid_d     = valid_q;
      reg_dst_d   = reg_dst_q;
      alu_src_d   = alu_src_q;
      alu_op_d    = alu_op_q;
      m_d         = m_q;
      wb_d        = wb_q;
      next_inst_d = next_inst_q;
      rd1_d       = rd1_q;
      rd2_d       = rd2_q;
      imm_d       = imm_q;
      jump_d      = jump_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;

      // Data fields follow the inputs on every non-stalled edge,
      // including bubbles, where they are don't-care.
      if (bus.flush_IN || !bus.stall_IN) begin
         next_inst_d = bus.nextInst_IN;
         rd1_d       = bus.regData1_IN;
         rd2_d       = bus.regData2_IN;
         imm_d       = bus.imm_IN;
         jump_d      = bus.jump_IN;
         rs_d        = bus.rs_IN;
         rt_d        = bus.rt_IN;
         rd_d        = bus.rd_IN;
      end

      priority case (1'b1)
         bus.flush_IN, hazard && !bus.stall_IN: begin
            valid_d   = 1'b0;
            reg_dst_d = 1'b0;
            alu_src_d = 1'b0;
            alu_op_d  = 2'b00;
            m_d       = '0;
            wb_d      = '0;
            cnt_d     = cnt_inc;
         end
         bus.stall_IN: begin
         end
         default: begin
            valid_d   = bus.valid_IN;
            reg_dst_d = bus.valid_IN & bus.EX_IN[3];
            alu_op_d  = bus.valid_IN ? bus.EX_IN[2:1] : 2'b00;
            alu_src_d = bus.valid_IN & bus.EX_IN[0];
            m_d       = bus.valid_IN ? bus.M_IN : '0;
            wb_d      = bus.valid_IN ? bus.WB_IN : '0;
         end
      endcase
   end

   always_ff @(posedge clk_BF or posedge rst_BF) begin
      if (rst_BF) begin
         valid_q     <= 1'b0;
         reg_dst_q   <= 1'b0;
         alu_src_q   <= 1'b0;
         alu_op_q    <= 2'b00;
         m_q         <= '0;
         wb_q        <= '0;
         next_inst_q <= '0;
         rd1_q       <= '0;
         rd2_q       <= '0;
         imm_q       <= '0;
         jump_q      <= '0;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         reg_dst_q   <= reg_dst_d;
         alu_src_q   <= alu_src_d;
         alu_op_q    <= alu_op_d;
         m_q         <= m_d;
         wb_q        <= wb_d;
         next_inst_q <= next_inst_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd2_d;
         imm_q       <= imm_d;
         jump_q      <= jump_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.hazard_OUT   = hazard;
   assign bus.valid_OUT    = valid_q;
   assign bus.RegDst       = reg_dst_q;
   assign bus.ALUSrc       = alu_src_q;
   assign bus.ALUOp        = alu_op_q;
   assign bus.M_OUT        = m_q;
   assign bus.WB_OUT       = wb_q;
   assign bus.nextInst_OUT = next_inst_q;
   assign bus.regData1_OUT = rd1_q;
   assign bus.regData2_OUT = rd2_q;
   assign bus.imm_OUT      = imm_q;
   assign bus.jump_OUT     = jump_q;
   assign bus.rs_OUT       = rs_q;
   assign bus.rt_OUT       = rt_q;
   assign bus.rd_OUT       = rd_q;
   assign bus.bubble_cnt   = cnt_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg (CNT_W=4 build).
// Stimulus pushes expected post-edge state; a monitor pops and compares.
module tb_id_ex_pipe_reg;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   id_ex_pipe_reg_if #(.CNT_W(4)) bus();

   id_ex_pipe_reg #(.CNT_W(4)) dut (
      .clk_BF(clk),
      .rst_BF(rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic        stall, flush, valid;
      logic [3:0]  ex, m;
      logic [1:0]  wb;
      logic [4:0]  rs, rt, rd;
      logic [7:0]  ni;
      logic [31:0] d1, d2, imm, jmp;
   } in_t;

   typedef struct packed {
      logic        v, rdst, asrc;
      logic [1:0]  aop;
      logic [3:0]  m;
      logic [1:0]  wb;
      logic [3:0]  cnt;
      logic [7:0]  ni;
      logic [31:0] d1, d2, imm, jmp;
      logic [4:0]  rs, rt, rd;
   } out_t;

   typedef struct {
      out_t  e;
      bit    haz;
      bit    chk_data;
      bit    async_chk;
      string nm;
   } ent_t;

   ent_t q[$];
   int   tests = 0;
   int   fails = 0;

   function automatic in_t mk(input logic v, input logic [3:0] ex,
                              input logic [3:0] m, input logic [1:0] wb,
                              input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] d1,
                              input logic [31:0] d2);
      in_t i;
      i = '0;
      i.valid = v; i.ex = ex; i.m = m; i.wb = wb;
      i.rs = rs; i.rt = rt; i.rd = rd; i.d1 = d1; i.d2 = d2;
      i.ni = 8'(d1 + 32'd4);
      i.imm = d2 ^ 32'h100;
      i.jmp = d1 << 2;
      return i;
   endfunction

   function automatic out_t dat(input in_t i, input logic [3:0] c);
      out_t o;
      o = '0;
      o.ni = i.ni; o.d1 = i.d1; o.d2 = i.d2;
      o.imm = i.imm; o.jmp = i.jmp;
      o.rs = i.rs; o.rt = i.rt; o.rd = i.rd;
      o.cnt = c;
      return o;
   endfunction

   function automatic out_t ld(input in_t i, input logic [3:0] c);
      out_t o;
      o = dat(i, c);
      o.v = i.valid;
      if (i.valid) begin
         o.rdst = i.ex[3]; o.aop = i.ex[2:1]; o.asrc = i.ex[0];
         o.m = i.m; o.wb = i.wb;
      end
      return o;
   endfunction

   function automatic out_t bub(input in_t i, input logic [3:0] c);
      return dat(i, c);
   endfunction

   function automatic out_t sample();
      out_t o;
      o.v = bus.valid_OUT; o.rdst = bus.RegDst; o.asrc = bus.ALUSrc;
      o.aop = bus.ALUOp; o.m = bus.M_OUT; o.wb = bus.WB_OUT;
      o.cnt = bus.bubble_cnt; o.ni = bus.nextInst_OUT;
      o.d1 = bus.regData1_OUT; o.d2 = bus.regData2_OUT;
      o.imm = bus.imm_OUT; o.jmp = bus.jump_OUT;
      o.rs = bus.rs_OUT; o.rt = bus.rt_OUT; o.rd = bus.rd_OUT;
      return o;
   endfunction

   function automatic logic [14:0] ctl(input out_t o);
      return {o.v, o.rdst, o.asrc, o.aop, o.m, o.wb, o.cnt};
   endfunction

   task automatic drive(input in_t i);
      bus.stall_IN = i.stall;       bus.flush_IN = i.flush;
      bus.valid_IN = i.valid;       bus.nextInst_IN = i.ni;
      bus.regData1_IN = i.d1;       bus.regData2_IN = i.d2;
      bus.imm_IN = i.imm;           bus.jump_IN = i.jmp;
      bus.rs_IN = i.rs;             bus.rt_IN = i.rt;
      bus.rd_IN = i.rd;             bus.M_IN = i.m;
      bus.WB_IN = i.wb;             bus.EX_IN = i.ex;
   endtask

   task automatic step(input in_t i, input out_t e, input bit haz,
                       input bit cd, input bit asy, input string nm);
      ent_t x;
      drive(i);
      x.e = e; x.haz = haz; x.chk_data = cd;
      x.async_chk = asy; x.nm = nm;
      q.push_back(x);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check(input ent_t x, input logic h);
      out_t a;
      bit   ok;
      a = sample();
      tests++;
      if (h !== x.haz) begin
         fails++;
         $display("FAIL %s hazard: got %0b want %0b", x.nm, h, x.haz);
      end
      tests++;
      ok = x.chk_data ? (a === x.e) : (ctl(a) === ctl(x.e));
      if (!ok) begin
         fails++;
         $display("FAIL %s regs: got %h want %h", x.nm, a, x.e);
      end
   endtask

   // Hazard is sampled just before the edge, registers just after it.
   initial begin : monitor
      ent_t  x;
      logic  h;
      forever begin
         @(negedge clk);
         #4;
         h = bus.hazard_OUT;
         if (q.size() > 0 && q[0].async_chk) begin
            x = q.pop_front();
            check(x, h);
         end else begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
               x = q.pop_front();
               check(x, h);
            end
         end
      end
   end

   initial begin : stim
      in_t  add, lw8, use8, lw0, use0, lw6, sw6;
      in_t  lw7, inv7, addb, sf, lw5, st, dead, fl;
      out_t x;
      drive('0);
      @(negedge clk);

      add = mk(1, 4'b1100, 4'b0000, 2'b10, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      step(add, '0, 1'b0, 1'b1, 1'b0, "reset_state");
      rst = 1'b0;

      step(add, ld(add, 4'd0), 1'b0, 1'b1, 1'b0, "load_add");

      lw8 = mk(1, 4'b0001, 4'b0010, 2'b11, 5'd1, 5'd8, 5'd0, 32'h40, 32'h44);
      step(lw8, ld(lw8, 4'd0), 1'b0, 1'b1, 1'b0, "load_lw8");

      use8 = mk(1, 4'b1100, 4'b0000, 2'b10, 5'd8, 5'd9, 5'd10, 32'h50, 32'h54);
      step(use8, bub(use8, 4'd1), 1'b1, 1'b0, 1'b0, "hazard_rs");
      step(use8, ld(use8, 4'd1), 1'b0, 1'b1, 1'b0, "reload_after_haz");

      lw0 = mk(1, 4'b0001, 4'b0010, 2'b11, 5'd2, 5'd0, 5'd0, 32'h60, 32'h64);
      step(lw0, ld(lw0, 4'd1), 1'b0, 1'b1, 1'b0, "load_lw0");
      use0 = mk(1, 4'b1100, 4'b0000, 2'b10, 5'd0, 5'd0, 5'd4, 32'h70, 32'h74);
      step(use0, ld(use0, 4'd1), 1'b0, 1'b1, 1'b0, "zero_no_haz");

      lw6 = mk(1, 4'b0001, 4'b0010, 2'b11, 5'd3, 5'd6, 5'd0, 32'h80, 32'h84);
      step(lw6, ld(lw6, 4'd1), 1'b0, 1'b1, 1'b0, "load_lw6");
      sw6 = mk(1, 4'b0001, 4'b0001, 2'b00, 5'd1, 5'd6, 5'd0, 32'h90, 32'h94);
      step(sw6, bub(sw6, 4'd2), 1'b1, 1'b0, 1'b0, "hazard_rt");

      lw7 = mk(1, 4'b0001, 4'b0010, 2'b11, 5'd3, 5'd7, 5'd0, 32'hA0, 32'hA4);
      step(lw7, ld(lw7, 4'd2), 1'b0, 1'b1, 1'b0, "load_lw7");
      inv7 = mk(0, 4'b1101, 4'b0010, 2'b11, 5'd7, 5'd1, 5'd2, 32'hB0, 32'hB4);
      step(inv7, ld(inv7, 4'd2), 1'b0, 1'b1, 1'b0, "invalid_in");

      addb = mk(1, 4'b1100, 4'b0000, 2'b10, 5'd4, 5'd5, 5'd6, 32'h11, 32'h12);
      step(addb, ld(addb, 4'd2), 1'b0, 1'b1, 1'b0, "load_addb");
      sf = addb;
      sf.stall = 1'b1; sf.flush = 1'b1; sf.d1 = 32'h33;
      step(sf, bub(sf, 4'd3), 1'b0, 1'b0, 1'b0, "flush_over_stall");

      lw5 = mk(1, 4'b0001, 4'b0010, 2'b11, 5'd2, 5'd5, 5'd0, 32'h22, 32'h24);
      x = ld(lw5, 4'd3);
      step(lw5, x, 1'b0, 1'b1, 1'b0, "load_lw5");
      for (int k = 0; k < 3; k++) begin
         st = mk(1, 4'b1100, 4'b0000, 2'b10, 5'd5, 5'd1, 5'd9,
                 32'h100 + 32'(k), 32'h200);
         st.stall = 1'b1;
         step(st, x, 1'b1, 1'b1, 1'b0, "stall_hold");
      end
      st.stall = 1'b0;
      step(st, bub(st, 4'd4), 1'b1, 1'b0, 1'b0, "haz_after_stall");

      dead = mk(1, 4'b1100, 4'b0011, 2'b01, 5'd1, 5'd2, 5'd3,
                32'hDEADBEEF, 32'h1);
      step(dead, ld(dead, 4'd4), 1'b0, 1'b1, 1'b0, "load_dead");

      rst = 1'b1;
      step(dead, '0, 1'b0, 1'b1, 1'b1, "async_reset");
      rst = 1'b0;

      for (int k = 1; k <= 17; k++) begin
         fl = dead;
         fl.flush = 1'b1;
         step(fl, bub(fl, (k > 15) ? 4'hF : 4'(k)), 1'b0, 1'b0, 1'b0,
              "flush_sat");
      end
      step(add, ld(add, 4'hF), 1'b0, 1'b1, 1'b0, "sat_hold_load");

      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
